logic_unit_arb: RTL
===================

LOGIC_UNIT_ARB -- requirements
Module: logic_unit_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req0, input, 1, requester 0 operation request.
REQ-005 The block SHALL have port op0, input, 2, requester 0 opcode.
REQ-006 The block SHALL have ports a0 and b0, input, WIDTH each, requester 0 operands.
REQ-007 The block SHALL have ports req1, op1, a1 and b1, defined as for requester 0.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle grant/accept pulses.
REQ-009 The block SHALL have port res_valid, output, 1, result register holds an unconsumed result.
REQ-010 The block SHALL have port res_ready, input, 1, consumer accepts the result this cycle.
REQ-011 The block SHALL have port res_id, output, 1, index of the requester that owns the result.
REQ-012 The block SHALL have port res_data, output, WIDTH, registered result.

Function
REQ-013 The block SHALL implement one shared bitwise logic unit with opcodes 00 = a&b, 01 = a|b, 10 = a^b, 11 = a&~b, bitwise over all WIDTH bits, with no carries.
REQ-014 The block SHALL define accept = !res_valid || res_ready; no grant when accept=0.
REQ-015 The block SHALL, when accept=1 and exactly one reqN=1, assert gntN combinationally in that cycle.
REQ-016 The block SHALL, when accept=1 and both requests are asserted, grant the requester not granted most recently (round-robin pointer last_gnt).
REQ-017 The block SHALL update last_gnt only on a grant; with no grant, last_gnt holds.
REQ-018 The block SHALL keep gnt0 and gnt1 mutually exclusive in every cycle.
REQ-019 The block SHALL, on a grant edge, load res_data with the logic result of the granted requester's op/a/b, load res_id with its index, and set res_valid=1; latency is 1 cycle from grant to res_valid.
REQ-020 Requesters SHALL hold req, op and operands stable until their grant cycle; the block samples them only in that cycle.
REQ-021 The block SHALL hold res_valid, res_id and res_data stable while res_valid=1 and res_ready=0.
REQ-022 The block SHALL, when res_valid=1, res_ready=1 and no request is present, clear res_valid on the next edge.
REQ-023 The block SHALL, when res_valid=1, res_ready=1 and a grant occurs in the same cycle, replace the result back-to-back with res_valid staying 1; sustained throughput is 1 operation per cycle.
REQ-024 The block SHALL ignore res_ready while res_valid=0.
REQ-025 The block SHALL, when reqN deasserts before being granted, drop the request without error; no request is queued internally.

Reset
REQ-026 The block SHALL, on reset=1, immediately force res_valid=0, res_id=0, res_data=0 and last_gnt=1, so requester 0 wins the first tie.
REQ-027 The block SHALL hold gnt0=gnt1=0 while reset=1, regardless of requests.
REQ-028 The block SHALL discard any result pending at reset assertion mid-operation; after reset deasserts, the first grant may occur in the first cycle.

Verification
REQ-029 The bench SHALL cover single request: after reset, req0=1, op0=00, a0=0xF0F0_F0F0, b0=0xFF00_FF00 -> gnt0 pulse; next cycle res_valid=1, res_id=0, res_data=0xF000_F000.
REQ-030 The bench SHALL cover a tie with round-robin: req0 and req1 held high, res_ready=1 -> grants alternate 0,1,0,1 in consecutive cycles; res_id follows one cycle later; no idle cycles.
REQ-031 The bench SHALL cover backpressure: a result is pending, res_ready=0, req1=1 with op1=10, a1=0xFFFF_FFFF, b1=0x1234_5678 -> gnt1=0 and res_data is held; when res_ready=1, gnt1 pulses that cycle; next res_data=0xEDCB_A987, res_id=1.
REQ-032 The bench SHALL cover the remaining opcodes: op=01 with a=0x0000_00FF, b=0x0000_FF00 -> 0x0000_FFFF; op=11 with a=0xFFFF_FFFF, b=0x0F0F_0F0F -> 0xF0F0_F0F0.
REQ-033 The bench SHALL cover drain: one result pending, res_ready=1, no requests -> res_valid=0 next cycle, and res_data keeps its last value.
REQ-034 The bench SHALL cover mid-operation reset: assert reset asynchronously between edges while res_valid=1 -> res_valid, res_id and res_data are 0 before the next edge, and both grants are 0; after release, a tie is granted to requester 0.

Source files
------------

// File: rtl/logic_unit_arb.sv
// Two-requester round-robin arbiter in front of one shared bitwise logic unit.
// The result sits in a single output register and is released with a valid/ready handshake.
module logic_unit_arb #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [WIDTH-1:0] res_data
);

    // Handshake: a result transfers on any edge where res_valid && res_ready.
    // The register may take a new result when it is empty or being drained in
    // the same cycle, which gives back-to-back issue at one operation per cycle.
    logic accept;
    logic pick1;
    logic last_gnt;

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = a & ~b;
        endcase
        return r;
    endfunction

    // On a tie the requester that was not granted most recently wins.
    always_comb begin
        accept = !res_valid || res_ready;
        pick1  = req1 && (!req0 || !last_gnt);
        gnt1   = !reset && accept && pick1;
        gnt0   = !reset && accept && req0 && !pick1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
            last_gnt  <= 1'b1;
        end else if (gnt0) begin
            res_valid <= 1'b1;
            res_id    <= 1'b0;
            res_data  <= logic_op(op0, a0, b0);
            last_gnt  <= 1'b0;
        end else if (gnt1) begin
            res_valid <= 1'b1;
            res_id    <= 1'b1;
            res_data  <= logic_op(op1, a1, b1);
            last_gnt  <= 1'b1;
        end else if (res_ready) begin
            // res_data keeps its last value after a drain
            res_valid <= 1'b0;
        end
    end

endmodule
